// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 4-bit combinational ALU: accepts register-addressed
// instructions, drives the ALU for one cycle and writes the result back with overflow tracking.
module alu_issue_ctrl #(
    parameter int DW     = 4,
    parameter int OVF_CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [1:0]        instr_rd,
    input  logic [1:0]        instr_ra,
    input  logic [1:0]        instr_rb,
    input  logic              ld_en,
    input  logic [1:0]        ld_addr,
    input  logic [DW-1:0]     ld_data,
    input  logic              ovf_clr,
    output logic [2:0]        alu_opcode,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    input  logic [DW-1:0]     alu_final,
    input  logic              alu_status,
    output logic              wb_valid,
    output logic [1:0]        wb_addr,
    output logic [DW-1:0]     wb_data,
    output logic              wb_status,
    output logic              ovf_sticky,
    output logic [OVF_CW-1:0] ovf_count,
    input  logic [1:0]        rd_addr,
    output logic [DW-1:0]     rd_data
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    localparam logic [OVF_CW-1:0] OVF_MAX = '1;

    state_t            state_q, state_d;
    logic              accept;
    logic              wb_fire;
    logic [DW-1:0]     regs_q [4];
    logic [2:0]        op_q;
    logic [DW-1:0]     a_q;
    logic [DW-1:0]     b_q;
    logic [1:0]        rd_q;
    logic              wb_valid_q;
    logic [1:0]        wb_addr_q;
    logic [DW-1:0]     wb_data_q;
    logic              wb_status_q;
    logic              ovf_sticky_q;
    logic [OVF_CW-1:0] ovf_count_q;

    assign accept  = instr_valid && instr_ready;
    assign wb_fire = (state_q == S_EXEC);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: no acceptance while reset is asserted, even though state is already IDLE
    always_comb begin
        instr_ready = 1'b0;
        if (state_q == S_IDLE && !rst) instr_ready = 1'b1;
    end

    // Operand latch: these registers drive the ALU directly and hold until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignment, so operands see the pre-edge register file; a same-edge load is not forwarded.
            op_q <= instr_op;
            a_q  <= regs_q[instr_ra];
            b_q  <= regs_q[instr_rb];
            rd_q <= instr_rd;
        end
    end

    // Register file: writeback takes priority over a direct load to the same address
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            // NOTE: this storage is reset explicitly because reset must leave every register at zero.
            if (rst)                              regs_q[i] <= '0;
            else if (wb_fire && rd_q == 2'(i))    regs_q[i] <= alu_final;
            else if (ld_en && ld_addr == 2'(i))   regs_q[i] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_status_q <= 1'b0;
        end else begin
            wb_valid_q <= wb_fire;
            if (wb_fire) begin
                wb_addr_q   <= rd_q;
                wb_data_q   <= alu_final;
                wb_status_q <= alu_status;
            end
        end
    end

    // Clear has priority over a coincident overflow writeback
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else if (wb_fire && alu_status) begin
            ovf_sticky_q <= 1'b1;
            if (ovf_count_q != OVF_MAX) ovf_count_q <= ovf_count_q + 1'b1;
        end
    end

    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign wb_status  = wb_status_q;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;
    assign rd_data    = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed instructions against a behavioural ALU, with a
// writeback scoreboard checked by an independent monitor.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_ra, instr_rb;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic       ovf_clr;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a, alu_b, alu_final;
    logic       alu_status;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic       wb_status;
    logic       ovf_sticky;
    logic [1:0] ovf_count;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] data;
        logic       st;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_issue_ctrl #(.DW(4), .OVF_CW(2)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ovf_clr(ovf_clr),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_final(alu_final), .alu_status(alu_status),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_status(wb_status),
        .ovf_sticky(ovf_sticky), .ovf_count(ovf_count),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU; Status is signed overflow, forced 0 for the logic ops
    always_comb begin
        alu_final  = '0;
        alu_status = 1'b0;
        case (alu_opcode)
            3'b000: alu_final = alu_a & alu_b;
            3'b001: alu_final = ~(alu_a & alu_b);
            3'b010: alu_final = alu_a | alu_b;
            3'b011: alu_final = alu_a ^ alu_b;
            3'b100: begin
                alu_final  = alu_a + alu_b;
                alu_status = (alu_a[3] == alu_b[3]) && (alu_final[3] != alu_a[3]);
            end
            3'b101: begin
                alu_final  = alu_a - alu_b;
                alu_status = (alu_a[3] != alu_b[3]) && (alu_final[3] != alu_a[3]);
            end
            3'b110: begin
                alu_final  = alu_b + 4'd1;
                alu_status = (alu_b == 4'h7);
            end
            default: begin
                alu_final  = alu_b - 4'd1;
                alu_status = (alu_b == 4'h8);
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expectation, including its cycle
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_wb_valid", wb_valid, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_addr", wb_addr, mon_e.addr);
                check("wb_data", wb_data, mon_e.data);
                check("wb_status", wb_status, mon_e.st);
                check("wb_latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [3:0] exp);
        rd_addr = a;
        #1;
        check($sformatf("rd_data_R%0d", a), rd_data, exp);
    endtask

    // Issues one instruction and returns once it has retired; optional side actions
    // on the accept edge (load) and on the writeback edge (clear, load to rd)
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [3:0] exp_d, input logic exp_s,
                         input bit clr_at_wb, input bit ld_acc, input logic [1:0] ld_acc_a,
                         input logic [3:0] ld_acc_d, input bit ld_wb, input logic [3:0] ld_wb_d);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        if (ld_acc) begin
            ld_en = 1'b1; ld_addr = ld_acc_a; ld_data = ld_acc_d;
        end
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("accept_timeout", instr_ready, 1'b1);
        e.addr = rd; e.data = exp_d; e.st = exp_s; e.cyc = cyc + 2;
        sb_q.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0; ld_en = 1'b0;
        check("ready_low_in_exec", instr_ready, 1'b0);
        if (clr_at_wb) ovf_clr = 1'b1;
        if (ld_wb) begin
            ld_en = 1'b1; ld_addr = rd; ld_data = ld_wb_d;
        end
        @(negedge clk);
        ovf_clr = 1'b0; ld_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_ra = '0;
        instr_rb = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ovf_clr = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("ready_during_reset", instr_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_ovf_sticky", ovf_sticky, 1'b0);
        check("reset_ovf_count", ovf_count, 2'd0);
        check("reset_alu_a", alu_a, 4'h0);
        check("reset_alu_opcode", alu_opcode, 3'd0);
        for (int i = 0; i < 4; i++) rd_check(2'(i), 4'h0);

        // 1: 5+3 overflows into 8
        load(2'd0, 4'd5); load(2'd1, 4'd3);
        issue(3'b100, 2'd2, 2'd0, 2'd1, 4'h8, 1'b1, 0, 0, 2'd0, 4'h0, 0, 4'h0);
        rd_check(2'd2, 4'h8);
        check("t1_ovf_count", ovf_count, 2'd1);
        check("t1_ovf_sticky", ovf_sticky, 1'b1);
        check("t1_alu_opcode_hold", alu_opcode, 3'b100);
        check("t1_alu_a_hold", alu_a, 4'd5);
        check("t1_alu_b_hold", alu_b, 4'd3);

        // 2: 2+3 no overflow; sticky stays set
        load(2'd0, 4'd2); load(2'd1, 4'd3);
        issue(3'b100, 2'd2, 2'd0, 2'd1, 4'h5, 1'b0, 0, 0, 2'd0, 4'h0, 0, 4'h0);
        rd_check(2'd2, 4'h5);
        check("t2_ovf_sticky", ovf_sticky, 1'b1);
        check("t2_ovf_count", ovf_count, 2'd1);

        // Load to ra on the accept edge is not forwarded; the register still takes it
        issue(3'b100, 2'd2, 2'd0, 2'd1, 4'h5, 1'b0, 0, 1, 2'd0, 4'd7, 0, 4'h0);
        rd_check(2'd0, 4'd7);
        // Writeback beats a same-edge load to rd: 7+3=A with overflow
        issue(3'b100, 2'd3, 2'd0, 2'd1, 4'hA, 1'b1, 0, 0, 2'd0, 4'h0, 1, 4'h1);
        rd_check(2'd3, 4'hA);
        check("wb_vs_ld_ovf_count", ovf_count, 2'd2);
        pulse_clr();
        check("clr_ovf_count", ovf_count, 2'd0);
        check("clr_ovf_sticky", ovf_sticky, 1'b0);

        // 3: DEC 8 -> 7 and INC 7 -> 8, both overflow; ra==rb
        load(2'd3, 4'd8);
        issue(3'b111, 2'd3, 2'd3, 2'd3, 4'h7, 1'b1, 0, 0, 2'd0, 4'h0, 0, 4'h0);
        rd_check(2'd3, 4'h7);
        issue(3'b110, 2'd3, 2'd3, 2'd3, 4'h8, 1'b1, 0, 0, 2'd0, 4'h0, 0, 4'h0);
        rd_check(2'd3, 4'h8);
        check("t3_ovf_count", ovf_count, 2'd2);

        // 4: 0-1 = F without overflow; NAND F,F = 0
        load(2'd0, 4'h0); load(2'd1, 4'h1);
        issue(3'b101, 2'd2, 2'd0, 2'd1, 4'hF, 1'b0, 0, 0, 2'd0, 4'h0, 0, 4'h0);
        load(2'd0, 4'hF); load(2'd1, 4'hF);
        issue(3'b001, 2'd2, 2'd0, 2'd1, 4'h0, 1'b0, 0, 0, 2'd0, 4'h0, 0, 4'h0);
        rd_check(2'd2, 4'h0);
        check("t4_ovf_count", ovf_count, 2'd2);

        // 5: reset during EXEC discards the instruction
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'b100; instr_rd = 2'd2; instr_ra = 2'd0; instr_rb = 2'd1;
        check("t5_ready_before_accept", instr_ready, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_ready_in_reset", instr_ready, 1'b0);
        check("t5_wb_valid_in_reset", wb_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after_reset", instr_ready, 1'b1);
        check("t5_ovf_count", ovf_count, 2'd0);
        check("t5_ovf_sticky", ovf_sticky, 1'b0);
        for (int i = 0; i < 4; i++) rd_check(2'(i), 4'h0);
        repeat (3) @(negedge clk);

        // 6: 2-bit counter saturates at 3; clear on an overflow writeback wins
        load(2'd0, 4'd5); load(2'd1, 4'd3);
        for (int k = 1; k <= 4; k++) begin
            issue(3'b100, 2'd2, 2'd0, 2'd1, 4'h8, 1'b1, 0, 0, 2'd0, 4'h0, 0, 4'h0);
            check($sformatf("t6_ovf_count_%0d", k), ovf_count, (k > 3) ? 32'd3 : 32'(k));
        end
        issue(3'b100, 2'd2, 2'd0, 2'd1, 4'h8, 1'b1, 1, 0, 2'd0, 4'h0, 0, 4'h0);
        check("t6_clr_wins_count", ovf_count, 2'd0);
        check("t6_clr_wins_sticky", ovf_sticky, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
